// File: rtl/minterm_serializer.sv
// minterm_serializer
// Captures an N_VARS-input truth table and streams the indices of its minterms
// (mode=0) or maxterms (mode=1) one per valid/ready transfer.
// Optional feature macro: MINTERM_GRAY_ORDER_EN (scan in reflected Gray order,
// i.e. Karnaugh-map adjacency order, instead of ascending binary order).
module minterm_serializer #(
  parameter int N_VARS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [(1<<N_VARS)-1:0]   table_in,
  input  logic                     mode,
  output logic                     busy,
  output logic                     term_valid,
  input  logic                     term_ready,
  output logic [N_VARS-1:0]        term_idx,
  output logic                     term_last,
  output logic                     done,
  output logic [N_VARS:0]          term_count
);

  localparam int W = 1 << N_VARS;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;

  // Bits still to be emitted; selected bits are cleared as they are accepted,
  // so "no other bit left" directly tells us the current term is the last.
  logic [W-1:0]      rem_mask;
  logic [N_VARS-1:0] pos;
  logic [N_VARS-1:0] idx;
  logic [W-1:0]      idx_onehot;
  logic              hit;
  logic              last_hit;
  logic              pos_end;
  logic              accept;

`ifdef MINTERM_GRAY_ORDER_EN
  // Map scan position to table index through reflected Gray code
  always_comb begin
    idx = pos ^ (pos >> 1);
  end
`else
  // Plain ascending order: the scan position is the table index
  always_comb begin
    idx = pos;
  end
`endif

  assign idx_onehot = W'(1) << idx;
  assign hit        = rem_mask[idx];
  assign last_hit   = ((rem_mask & ~idx_onehot) == '0);
  assign pos_end    = (pos == {N_VARS{1'b1}});
  assign accept     = (state == EMIT) && term_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    term_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (hit) begin
          state_nxt = EMIT;
        end else if (pos_end) begin
          state_nxt = DONE;
        end
      end
      EMIT: begin
        busy       = 1'b1;
        term_valid = 1'b1;
        if (term_ready) begin
          state_nxt = term_last ? DONE : SCAN;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Scan datapath: capture, position stepping, term register and counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_mask   <= '0;
      pos        <= '0;
      term_idx   <= '0;
      term_last  <= 1'b0;
      term_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rem_mask   <= mode ? ~table_in : table_in;
            pos        <= '0;
            term_count <= '0;
          end
        end
        SCAN: begin
          if (hit) begin
            term_idx  <= idx;
            term_last <= last_hit;
          end else if (!pos_end) begin
            pos <= pos + N_VARS'(1);
          end
        end
        EMIT: begin
          if (accept) begin
            term_count <= term_count + (N_VARS+1)'(1);
            rem_mask   <= rem_mask & ~idx_onehot;
            term_last  <= 1'b0;
            if (!term_last) begin
              pos <= pos + N_VARS'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minterm_serializer.sv
// tb_minterm_serializer
// Randomized and directed scans checked against a term-list model built
// straight from the truth table. Honours MINTERM_GRAY_ORDER_EN like the DUT.
module tb_minterm_serializer;

  localparam int NV = 4;
  localparam int W  = 1 << NV;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  table_in;
  logic          mode;
  logic          busy;
  logic          term_valid;
  logic          term_ready;
  logic [NV-1:0] term_idx;
  logic          term_last;
  logic          done;
  logic [NV:0]   term_count;

  int checks;
  int errors;

  minterm_serializer #(.N_VARS(NV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .table_in   (table_in),
    .mode       (mode),
    .busy       (busy),
    .term_valid (term_valid),
    .term_ready (term_ready),
    .term_idx   (term_idx),
    .term_last  (term_last),
    .done       (done),
    .term_count (term_count)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Scan order of the function's inputs
  function automatic int orderOf(input int p);
`ifdef MINTERM_GRAY_ORDER_EN
    return p ^ (p >> 1);
`else
    return p;
`endif
  endfunction

  // Run one scan from IDLE. readyPct is the chance term_ready is high per cycle;
  // stallFirst holds term_ready low for that many cycles on the first term.
  // resetAtTerm >= 0 pulls rst_n low while that term index (0-based) is valid.
  task automatic applyStimulus(input logic [W-1:0] tbl, input logic md,
                               input int readyPct, input int stallFirst,
                               input int resetAtTerm);
    int expIdx[$];
    int lastPos;
    int k;
    int cyc;
    int stalls;
    int stallLeft;
    int latency;
    bit finished;
    bit prevHeld;
    logic [NV-1:0] prevIdx;
    logic prevLast;
    bit sel;

    lastPos = -1;
    for (int p = 0; p < W; p++) begin
      sel = md ? ~tbl[orderOf(p)] : tbl[orderOf(p)];
      if (sel) begin
        expIdx.push_back(orderOf(p));
        lastPos = p;
      end
    end

    @(negedge clk);
    start    = 1'b1;
    table_in = tbl;
    mode     = md;
    term_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    checkOutput("busy_after_start", {31'b0, busy}, 32'd1);

    k = 0;
    stalls = 0;
    stallLeft = stallFirst;
    finished = 0;
    prevHeld = 0;
    prevIdx = '0;
    prevLast = 1'b0;
    while (!finished && cyc < 2000) begin
      if (done) begin
        finished = 1;
      end else begin
        if (term_valid && prevHeld) begin
          checkOutput("held_idx", {28'b0, term_idx}, {28'b0, prevIdx});
          checkOutput("held_last", {31'b0, term_last}, {31'b0, prevLast});
        end
        if (term_valid && resetAtTerm == k) begin
          rst_n = 1'b0;
          term_ready = 1'b1;
          @(negedge clk);
          checkOutput("rst_valid", {31'b0, term_valid}, 32'd0);
          checkOutput("rst_busy", {31'b0, busy}, 32'd0);
          checkOutput("rst_done", {31'b0, done}, 32'd0);
          checkOutput("rst_last", {31'b0, term_last}, 32'd0);
          checkOutput("rst_idx", {28'b0, term_idx}, 32'd0);
          checkOutput("rst_count", {27'b0, term_count}, 32'd0);
          rst_n = 1'b1;
          term_ready = 1'b0;
          for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("post_rst_done", {31'b0, done}, 32'd0);
          end
          return;
        end
        if (term_valid && k == 0 && stallLeft > 0) begin
          term_ready = 1'b0;
          stallLeft--;
        end else begin
          term_ready = ($urandom_range(99) < readyPct) ? 1'b1 : 1'b0;
        end
        // Junk on start/table_in/mode while busy must be ignored
        if ($urandom_range(9) < 3) begin
          start    = 1'b1;
          table_in = W'($urandom);
          mode     = 1'($urandom);
        end else begin
          start = 1'b0;
        end
        if (term_valid) begin
          if (term_ready) begin
            if (k < expIdx.size()) begin
              checkOutput("term_idx", {28'b0, term_idx}, 32'(expIdx[k]));
              checkOutput("term_last", {31'b0, term_last},
                          (k == expIdx.size() - 1) ? 32'd1 : 32'd0);
            end else begin
              checkOutput("extra_term", 32'(k), 32'(expIdx.size()));
            end
            k++;
            prevHeld = 0;
          end else begin
            stalls++;
            prevHeld = 1;
            prevIdx  = term_idx;
            prevLast = term_last;
          end
        end else begin
          prevHeld = 0;
        end
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end

    if (!finished) begin
      checkOutput("timeout", 32'd0, 32'd1);
      return;
    end
    if (lastPos < 0) begin
      latency = W + 1;
    end else begin
      latency = lastPos + 1 + expIdx.size() + stalls + 1;
    end
    checkOutput("done_cycle", 32'(cyc), 32'(latency));
    checkOutput("done_busy", {31'b0, busy}, 32'd0);
    checkOutput("done_valid", {31'b0, term_valid}, 32'd0);
    checkOutput("terms_seen", 32'(k), 32'(expIdx.size()));
    checkOutput("term_count", {27'b0, term_count}, 32'(expIdx.size()));
    term_ready = 1'b0;
    @(negedge clk);
    checkOutput("done_pulse", {31'b0, done}, 32'd0);
    checkOutput("count_hold", {27'b0, term_count}, 32'(expIdx.size()));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    table_in = '0;
    mode = 1'b0;
    term_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_valid", {31'b0, term_valid}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_count", {27'b0, term_count}, 32'd0);
    rst_n = 1'b1;

    // Reset during the third term, then an empty table
    applyStimulus(16'h62B4, 1'b0, 100, 0, 2);
    applyStimulus(16'h0000, 1'b0, 100, 0, -1);
    // Minterms, maxterms, backpressure, full table, empty maxterm table
    applyStimulus(16'h62B4, 1'b0, 100, 0, -1);
    applyStimulus(16'h62B4, 1'b1, 100, 0, -1);
    applyStimulus(16'h62B4, 1'b0, 100, 5, -1);
    applyStimulus(16'hFFFF, 1'b0, 100, 0, -1);
    applyStimulus(16'hFFFF, 1'b1, 60, 0, -1);
    applyStimulus(16'h8000, 1'b0, 50, 2, -1);
    // Random tables, modes and ready behaviour
    for (int n = 0; n < 25; n++) begin
      applyStimulus(W'($urandom), 1'($urandom), 20 + $urandom_range(80),
                    $urandom_range(3), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
